// File: rtl/bus_arbiter_pkg.sv
// bus_arbiter_pkg: FSM state type, arbitration-mode constants and the
// destination-ID extraction helper shared by the bus_arbiter_gen slice.
package bus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        POP     = 2'd1,
        DELIVER = 2'd2,
        PUSH    = 2'd3
    } state_t;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    // Upper bounds for the helper's generic argument/result widths.
    localparam int MAX_PCKG_SZ = 256;
    localparam int MAX_ID_W    = 32;

    // Return the ID field pkt[pkt_sz-1 -: id_w], zero-extended to MAX_ID_W.
    function automatic logic [MAX_ID_W-1:0] dst_of(
        input logic [MAX_PCKG_SZ-1:0] pkt,
        input int                     pkt_sz,
        input int                     id_w
    );
        logic [MAX_ID_W-1:0] keep;
        keep = ~({MAX_ID_W{1'b1}} << id_w);
        return MAX_ID_W'(pkt >> (pkt_sz - id_w)) & keep;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: purely combinational requester selection. mode=1 searches
// round-robin starting one past ptr; mode=0 picks the lowest set index.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    input  logic             mode,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Walk the candidates in priority order and take the first requester
    always_comb begin
        int cand;
        cand = 0;
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        for (int k = 0; k < N; k++) begin
            cand = mode ? (int'(ptr) + 1 + k) % N : k;
            if (!any && req[cand]) begin
                any       = 1'b1;
                gnt[cand] = 1'b1;
                idx       = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/bus_arbiter_gen.sv
// bus_arbiter_gen: N-driver packet generator/arbiter. Pops one packet at a
// time from FWFT source FIFOs, decodes its destination ID and pushes it to
// one destination (unicast) or all other drivers (broadcast), stalling on
// destination full and dropping packets with an invalid destination.
// Optional macro BUS_ARB_DROP_CNT_EN enables the saturating drop counter;
// without it drop_cnt is tied to zero.
module bus_arbiter_gen
    import bus_arbiter_pkg::*;
#(
    parameter int              PCKG_SZ   = 32,
    parameter int              DRVRS     = 4,
    parameter int              ID_W      = 8,
    parameter logic [ID_W-1:0] BROADCAST = {ID_W{1'b1}},
    parameter int              ARB_MODE  = ARB_RR
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DRVRS-1:0]         pndng,
    input  logic [DRVRS*PCKG_SZ-1:0] D_pop,
    output logic [DRVRS-1:0]         pop,
    input  logic [DRVRS-1:0]         full,
    output logic [DRVRS-1:0]         push,
    output logic [PCKG_SZ-1:0]       D_push,
    output logic [15:0]              drop_cnt
);

    localparam int   IDX_W = $clog2(DRVRS);
    localparam logic RR_EN = (ARB_MODE == ARB_RR);

    state_t             state, state_nx;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   gidx_q;
    logic [IDX_W-1:0]   src_q;
    logic [IDX_W-1:0]   arb_idx;
    logic [DRVRS-1:0]   arb_gnt;
    logic               arb_any;
    logic [PCKG_SZ-1:0] pkt_q;
    logic [MAX_ID_W-1:0] dst;
    logic               dst_bcast;
    logic               dst_ok;
    logic [DRVRS-1:0]   mask;
    logic               stall;
    logic               deliver_go;
    logic [DRVRS-1:0]   pop_nx;
    logic [DRVRS-1:0]   push_nx;

    rr_arbiter #(
        .N     (DRVRS),
        .IDX_W (IDX_W)
    ) u_arb (
        .req  (pndng),
        .ptr  (rr_ptr),
        .mode (RR_EN),
        .gnt  (arb_gnt),
        .idx  (arb_idx),
        .any  (arb_any)
    );

    // Decode the held packet's destination into a target mask and stall flag
    always_comb begin
        dst       = dst_of(MAX_PCKG_SZ'(pkt_q), PCKG_SZ, ID_W);
        dst_bcast = (dst == MAX_ID_W'(BROADCAST));
        dst_ok    = dst_bcast || (dst < MAX_ID_W'(DRVRS));
        mask      = '0;
        for (int i = 0; i < DRVRS; i++) begin
            if (dst_bcast) begin
                mask[i] = (IDX_W'(i) != src_q);
            end else begin
                mask[i] = (dst == MAX_ID_W'(i));
            end
        end
        stall      = |(mask & full);
        deliver_go = (state == DELIVER) && dst_ok && !stall;
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // FSM next-state: one packet walks IDLE -> POP -> DELIVER -> PUSH
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (arb_any) state_nx = POP;
            POP:     state_nx = DELIVER;
            DELIVER: begin
                if (!dst_ok) begin
                    state_nx = IDLE;
                end else if (!stall) begin
                    state_nx = PUSH;
                end
            end
            PUSH:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // FSM outputs: next values of the registered pop/push strobes
    always_comb begin
        pop_nx  = '0;
        push_nx = '0;
        if (state == IDLE) begin
            pop_nx = arb_gnt;
        end
        if (deliver_go) begin
            push_nx = mask;
        end
    end

    // Registered strobes, delivery data, winner index and round-robin pointer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pop    <= '0;
            push   <= '0;
            D_push <= '0;
            gidx_q <= '0;
            rr_ptr <= IDX_W'(DRVRS - 1);
        end else begin
            pop  <= pop_nx;
            push <= push_nx;
            if (deliver_go) begin
                D_push <= pkt_q;
            end
            if (state == IDLE) begin
                gidx_q <= arb_idx;
            end
            if (state == POP && RR_EN) begin
                rr_ptr <= gidx_q;
            end
        end
    end

    // Capture the popped FIFO head and its source at the close of POP
    always_ff @(posedge clk) begin
        if (state == POP) begin
            pkt_q <= D_pop[int'(gidx_q)*PCKG_SZ +: PCKG_SZ];
            src_q <= gidx_q;
        end
    end

`ifdef BUS_ARB_DROP_CNT_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Count invalid-destination drops, holding at all-ones
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_cnt <= '0;
        end else if (state == DELIVER && !dst_ok) begin
            drop_cnt <= sat_inc16(drop_cnt);
        end
    end
`else
    assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_bus_arbiter_gen.sv
// tb_bus_arbiter_gen: directed bench for bus_arbiter_gen. Two instances share
// stimulus: dut_rr (round-robin) and dut_fx (fixed priority).
module tb_bus_arbiter_gen;

`ifdef BUS_ARB_DROP_CNT_EN
    localparam int DROP_EN = 1;
`else
    localparam int DROP_EN = 0;
`endif

    logic         clk;
    logic         reset;
    logic [3:0]   pndng;
    logic [127:0] d_pop;
    logic [3:0]   full;
    logic [3:0]   pop_rr, push_rr, pop_fx, push_fx;
    logic [31:0]  dpush_rr, dpush_fx;
    logic [15:0]  drop_rr, drop_fx;

    int vec  = 0;
    int miss = 0;

    bus_arbiter_gen #(.PCKG_SZ(32), .DRVRS(4), .ID_W(8), .ARB_MODE(1)) dut_rr (
        .clk(clk), .reset(reset), .pndng(pndng), .D_pop(d_pop), .pop(pop_rr),
        .full(full), .push(push_rr), .D_push(dpush_rr), .drop_cnt(drop_rr)
    );

    bus_arbiter_gen #(.PCKG_SZ(32), .DRVRS(4), .ID_W(8), .ARB_MODE(0)) dut_fx (
        .clk(clk), .reset(reset), .pndng(pndng), .D_pop(d_pop), .pop(pop_fx),
        .full(full), .push(push_fx), .D_push(dpush_fx), .drop_cnt(drop_fx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        pndng = 4'hF;
        full  = 4'h0;
        d_pop = {32'h0100_0003, 32'h0100_0002, 32'h0100_0001, 32'h0100_0000};
        for (int i = 0; i < 3; i++) begin
            tick();
            vec++; if (pop_rr !== 4'b0000) begin miss++; $display("FAIL rst_pop: got %b want 0000", pop_rr); end
            vec++; if (push_rr !== 4'b0000) begin miss++; $display("FAIL rst_push: got %b want 0000", push_rr); end
        end
        vec++; if (dpush_rr !== 32'h0) begin miss++; $display("FAIL rst_dpush: got %h want 0", dpush_rr); end
        vec++; if (drop_rr !== 16'h0) begin miss++; $display("FAIL rst_drop: got %h want 0", drop_rr); end
        reset = 1'b1;
        #1;
        vec++; if (pop_rr !== 4'b0000) begin miss++; $display("FAIL rel_early_pop: got %b want 0000", pop_rr); end
        tick();
        vec++; if (pop_rr !== 4'b0001) begin miss++; $display("FAIL rel_pop_rr: got %b want 0001", pop_rr); end
        vec++; if (pop_fx !== 4'b0001) begin miss++; $display("FAIL rel_pop_fx: got %b want 0001", pop_fx); end
        pndng = 4'h0;
        tick();
        tick();
        vec++; if (push_rr !== 4'b0010) begin miss++; $display("FAIL rel_push: got %b want 0010", push_rr); end
        tick();
    endtask

    task automatic test_unicast();
        pndng = 4'b0100;
        d_pop[2*32 +: 32] = 32'h01AB_CDEF;
        tick();
        vec++; if (pop_rr !== 4'b0100) begin miss++; $display("FAIL uni_pop: got %b want 0100", pop_rr); end
        pndng = 4'h0;
        tick();
        vec++; if (pop_rr !== 4'b0000) begin miss++; $display("FAIL uni_pop_once: got %b want 0000", pop_rr); end
        vec++; if (push_rr !== 4'b0000) begin miss++; $display("FAIL uni_push_early: got %b want 0000", push_rr); end
        tick();
        vec++; if (push_rr !== 4'b0010) begin miss++; $display("FAIL uni_push: got %b want 0010", push_rr); end
        vec++; if (dpush_rr !== 32'h01AB_CDEF) begin miss++; $display("FAIL uni_data: got %h want 01abcdef", dpush_rr); end
        vec++; if (dpush_fx !== 32'h01AB_CDEF) begin miss++; $display("FAIL uni_data_fx: got %h want 01abcdef", dpush_fx); end
        tick();
        vec++; if (push_rr !== 4'b0000) begin miss++; $display("FAIL uni_push_once: got %b want 0000", push_rr); end
        vec++; if (dpush_rr !== 32'h01AB_CDEF) begin miss++; $display("FAIL uni_data_hold: got %h want 01abcdef", dpush_rr); end
    endtask

    task automatic test_broadcast();
        pndng = 4'b0001;
        d_pop[0 +: 32] = 32'hFF12_3456;
        tick();
        vec++; if (pop_rr !== 4'b0001) begin miss++; $display("FAIL bc_pop: got %b want 0001", pop_rr); end
        pndng = 4'h0;
        tick();
        tick();
        vec++; if (push_rr !== 4'b1110) begin miss++; $display("FAIL bc_push: got %b want 1110", push_rr); end
        vec++; if (dpush_rr !== 32'hFF12_3456) begin miss++; $display("FAIL bc_data: got %h want ff123456", dpush_rr); end
        tick();
        vec++; if (push_rr !== 4'b0000) begin miss++; $display("FAIL bc_push_once: got %b want 0000", push_rr); end
    endtask

    task automatic test_backpressure();
        full  = 4'b1000;
        pndng = 4'b0010;
        d_pop[1*32 +: 32] = 32'h0300_0001;
        tick();
        vec++; if (pop_rr !== 4'b0010) begin miss++; $display("FAIL bp_pop: got %b want 0010", pop_rr); end
        pndng = 4'h0;
        for (int i = 0; i < 9; i++) begin
            tick();
            vec++; if (push_rr !== 4'b0000) begin miss++; $display("FAIL bp_stall: cycle %0d got %b want 0000", i, push_rr); end
        end
        full = 4'b0000;
        tick();
        vec++; if (push_rr !== 4'b1000) begin miss++; $display("FAIL bp_push: got %b want 1000", push_rr); end
        vec++; if (dpush_rr !== 32'h0300_0001) begin miss++; $display("FAIL bp_data: got %h want 03000001", dpush_rr); end
        tick();
        vec++; if (push_rr !== 4'b0000) begin miss++; $display("FAIL bp_push_once: got %b want 0000", push_rr); end
    endtask

    task automatic test_invalid();
        pndng = 4'b1000;
        d_pop[3*32 +: 32] = 32'h0700_0000;
        tick();
        vec++; if (pop_rr !== 4'b1000) begin miss++; $display("FAIL inv_pop: got %b want 1000", pop_rr); end
        pndng = 4'h0;
        tick();
        tick();
        vec++; if (push_rr !== 4'b0000) begin miss++; $display("FAIL inv_push: got %b want 0000", push_rr); end
        vec++; if (drop_rr !== 16'(DROP_EN)) begin miss++; $display("FAIL inv_drop1: got %0d want %0d", drop_rr, DROP_EN); end
        tick();
        vec++; if (push_rr !== 4'b0000) begin miss++; $display("FAIL inv_push_late: got %b want 0000", push_rr); end
        // ID equal to DRVRS is the first invalid value
        pndng = 4'b0001;
        d_pop[0 +: 32] = 32'h0400_0000;
        tick();
        vec++; if (pop_rr !== 4'b0001) begin miss++; $display("FAIL inv4_pop: got %b want 0001", pop_rr); end
        pndng = 4'h0;
        tick();
        tick();
        vec++; if (push_rr !== 4'b0000) begin miss++; $display("FAIL inv4_push: got %b want 0000", push_rr); end
        vec++; if (drop_fx !== 16'(2*DROP_EN)) begin miss++; $display("FAIL inv4_drop: got %0d want %0d", drop_fx, 2*DROP_EN); end
        tick();
        // unicast back to the sender is a normal delivery
        pndng = 4'b0010;
        d_pop[1*32 +: 32] = 32'h0100_0055;
        tick();
        pndng = 4'h0;
        tick();
        tick();
        vec++; if (push_rr !== 4'b0010) begin miss++; $display("FAIL self_push: got %b want 0010", push_rr); end
        vec++; if (dpush_rr !== 32'h0100_0055) begin miss++; $display("FAIL self_data: got %h want 01000055", dpush_rr); end
        tick();
    endtask

    task automatic test_reset_abort();
        pndng = 4'b0001;
        d_pop[0 +: 32] = 32'h0200_0000;
        tick();
        vec++; if (pop_rr !== 4'b0001) begin miss++; $display("FAIL abort_pop: got %b want 0001", pop_rr); end
        pndng = 4'h0;
        tick();
        reset = 1'b0;
        #1;
        vec++; if (pop_rr !== 4'b0000) begin miss++; $display("FAIL abort_pop_clr: got %b want 0000", pop_rr); end
        vec++; if (dpush_rr !== 32'h0) begin miss++; $display("FAIL abort_dpush: got %h want 0", dpush_rr); end
        vec++; if (drop_rr !== 16'h0) begin miss++; $display("FAIL abort_drop: got %0d want 0", drop_rr); end
        tick();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            vec++; if (push_rr !== 4'b0000) begin miss++; $display("FAIL abort_push: cycle %0d got %b want 0000", i, push_rr); end
        end
    endtask

    task automatic test_round_robin();
        int rr_ord[5];
        rr_ord = '{0, 1, 2, 3, 0};
        d_pop = {32'h0000_0003, 32'h0000_0002, 32'h0000_0001, 32'h0000_0000};
        pndng = 4'hF;
        for (int j = 0; j < 5; j++) begin
            tick();
            vec++; if (pop_rr !== 4'(1 << rr_ord[j])) begin miss++; $display("FAIL rr_order[%0d]: got %b want driver %0d", j, pop_rr, rr_ord[j]); end
            vec++; if (pop_fx !== 4'b0001) begin miss++; $display("FAIL fx_order[%0d]: got %b want 0001", j, pop_fx); end
            if (j == 4) pndng = 4'h0;
            tick();
            vec++; if (pop_rr !== 4'b0000) begin miss++; $display("FAIL rr_pop_once[%0d]: got %b want 0000", j, pop_rr); end
            tick();
            vec++; if (push_fx !== 4'b0001) begin miss++; $display("FAIL fx_push[%0d]: got %b want 0001", j, push_fx); end
            tick();
        end
        tick();
        vec++; if (pop_rr !== 4'b0000) begin miss++; $display("FAIL rr_idle: got %b want 0000", pop_rr); end
    endtask

    initial begin
        test_reset();
        test_unicast();
        test_broadcast();
        test_backpressure();
        test_invalid();
        test_reset_abort();
        test_round_robin();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: sim time limit reached, got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/bus_arbiter_gen.md
Name: bus_arbiter_gen

Overview:
- Parametrised successor to the single-bus generator/arbiter: N drivers, each fronted by a first-word-fall-through (FWFT) source FIFO.
- Packets carry a destination-ID header; the block routes each to one destination (unicast) or to all others (broadcast).
- Adds selectable arbitration mode, destination backpressure and invalid-destination drop.
- Sits between the driver-side FIFOs and the shared delivery bus; the environment's drivers and monitors connect here.

Parameters:
- PCKG_SZ, 32, packet width in bits.
- DRVRS, 4, number of drivers/ports (2..16).
- ID_W, 8, destination-ID field width; field = D[PCKG_SZ-1 -: ID_W].
- BROADCAST, {ID_W{1'b1}} (8'hFF), broadcast ID value.
- ARB_MODE, 1, arbitration mode: 0 = fixed priority (lowest index wins), 1 = round-robin.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- pndng  in  DRVRS  source FIFO i non-empty.
- D_pop  in  DRVRS*PCKG_SZ  head of FIFO i at bits [i*PCKG_SZ +: PCKG_SZ]; FWFT.
- pop  out  DRVRS  one-hot, one-cycle pop strobe to FIFO i.
- full  in  DRVRS  destination i cannot accept.
- push  out  DRVRS  push strobe per destination; more than one bit may be set (broadcast).
- D_push  out  PCKG_SZ  shared delivery data, valid while any push bit is set.
- drop_cnt  out  16  invalid-destination drop counter (see Optional Feature).

Behaviour:
- Reset (reset=0, async): pop=0, push=0, D_push=0, drop_cnt=0, state=IDLE, rr_ptr=DRVRS-1, held packet discarded. Reset mid-transaction aborts the transaction with no pop and no push afterwards.
- All outputs are registered.
- FSM IDLE -> POP -> DELIVER -> PUSH -> IDLE.
- IDLE:
  - If |pndng, select winner g and go to POP.
  - Mode 1: search starts at rr_ptr+1, mod DRVRS.
  - Mode 0: lowest set index.
- POP: pop[g]=1 for exactly this cycle. Latch D_pop[g] and src=g at the closing edge. Mode 1: rr_ptr<=g.
- DELIVER, destination decode from dst = latched[PCKG_SZ-1 -: ID_W]:
  - dst==BROADCAST: target mask = all drivers except src.
  - dst<DRVRS: mask = one-hot(dst). Unicast to self (dst==src) is delivered normally.
  - Otherwise: invalid. Drop, no push, return to IDLE next cycle.
  - Stall in DELIVER while (mask & full)!=0.
  - Otherwise go to PUSH with push<=mask and D_push<=latched.
- PUSH: push and D_push valid for exactly one cycle. Next cycle push=0; D_push holds its last value.
- Latency:
  - pndng sampled in IDLE at cycle N -> pop at N+1 -> push at N+3 (no stall).
  - Throughput: one packet per 4 cycles.
- pndng dropping between the IDLE sample and POP is a protocol violation by the FIFO; the block pops regardless.
- A broadcast from a single-driver system (DRVRS=1 excluded by range) never occurs. A broadcast mask is never empty because DRVRS>=2.

Optional Feature:
- Macro BUS_ARB_DROP_CNT_EN.
- Defined: drop_cnt increments by 1 on each invalid-destination drop and saturates at 16'hFFFF.
- Undefined: drop_cnt is tied to 0; drop behaviour is otherwise identical.

Decomposition:
- Package bus_arbiter_pkg holds:
  - state enum (IDLE, POP, DELIVER, PUSH);
  - ARB_FIXED/ARB_RR constants;
  - function dst_of(pkt) returning the ID field.
- Sub-module rr_arbiter: pndng, ptr, mode -> one-hot grant + index; purely combinational, reusable.

Test Plan:
- Reset: hold reset=0 with pndng=4'hF -> pop=0, push=0, D_pop ignored. Release -> first pop occurs no earlier than 1 cycle after the IDLE sample.
- Unicast: pndng[2]=1, D_pop[2]=32'h01AB_CDEF -> pop=4'b0100 at N+1, push=4'b0010 and D_push=32'h01AB_CDEF at N+3, single cycle each.
- Broadcast: driver 0 sends 32'hFF12_3456 -> push=4'b1110, D_push=32'hFF12_3456.
- Round-robin: ARB_MODE=1, pndng=4'hF held -> grant order 0,1,2,3,0. With ARB_MODE=0 -> 0,0,0.
- Backpressure: driver 1 sends 32'h0300_0001 with full[3]=1 for 10 cycles -> no push while full; push=4'b1000 one cycle after full deasserts.
- Invalid destination: driver 3 sends 32'h0700_0000 -> pop asserted, no push. drop_cnt=1 with BUS_ARB_DROP_CNT_EN, 0 without.
